wb_ram_bank: RTL and testbench
==============================

# wb_ram_bank

Parametrised Wishbone B3 slave RAM: the next-generation on-chip memory for the SoC template, generalising the fixed 32-bit, four-byte-lane BRAM bank to any power-of-two data width and depth. It adds a real Wishbone handshake with registered ack, out-of-range error response and registered-feedback incrementing/wrapping bursts, so it sits directly on the interconnect as instruction or data memory.

## Interface
- `DATA_WIDTH`, 32: bus/word width; multiple of 8, power of two (8..128).
- `DEPTH`, 8192: words; power of two.
- `INIT_FILE`, "": hex file loaded by `$readmemh` when non-empty.
- `BURST_EN`, 1: 0 treats every cycle as classic (CTI ignored).
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wb_adr_i`  in  32  byte address; word index = `adr[LSB +: AW]`, LSB = log2(DATA_WIDTH/8), AW = log2(DEPTH).
- `wb_dat_i`  in  DATA_WIDTH  write data.
- `wb_sel_i`  in  DATA_WIDTH/8  byte-lane enables.
- `wb_we_i`, `wb_cyc_i`, `wb_stb_i`  in  1  standard Wishbone controls.
- `wb_cti_i`  in  3  000 classic, 010 incrementing, 111 end-of-burst.
- `wb_bte_i`  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- `wb_dat_o`  out  DATA_WIDTH  read data, valid with ack.
- `wb_ack_o`, `wb_err_o`  out  1  transfer termination.

## Operation
- States: IDLE, SINGLE, BURST.
- IDLE: on `cyc&stb` latch word index into `addr_q`; in-range -> SINGLE if CTI≠010 (or !BURST_EN), else BURST; out-of-range (any bit of `adr` above LSB+AW set) -> SINGLE with err flag.
- SINGLE: assert ack (or err) for exactly one cycle; return to IDLE.
- BURST: ack held while `cyc&stb`; each cycle with ack&stb is one beat; `addr_q` advances per bte (wrap modes replace low 2/3/4 bits with incremented value, upper bits fixed; linear increments full index). Beat with CTI=111 is last -> IDLE. Linear increment past DEPTH-1 -> that beat answers err, no write, -> IDLE.
- `wb_stb_i` low in BURST: ack low, address and memory output held (memory enable off); resume on stb.
- `wb_cyc_i` low in any state -> IDLE next edge; ack/err gated combinationally by `cyc&stb`.
- Writes commit only on an ack beat with `we`: bytes where `sel`=1 written at `addr_q`; others unchanged. err beats never write.
- Reads: memory read address = `wb_adr_i` word index in IDLE, next `addr_q` in BURST, so data is ready with the following ack.
- err data: `wb_dat_o` = 0.

## Timing
- Reset: state IDLE, `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0, `addr_q`=0; memory contents not reset. Reset mid-burst aborts immediately; no further writes.
- Classic: stb sampled at edge N -> ack during cycle N+1, drops at N+2; 2 cycles/transfer; back-to-back allowed (new stb sampled at N+2).
- Burst: first ack at N+1, then one beat per cycle; B beats take B+1 cycles absent wait states.
- Write at cycle N then read same word at N+1 returns new data (write commits at edge ending N).
- Simultaneous cyc drop and last beat: beat not counted, no write.

## Structure
- Package `wb_ram_pkg`: CTI/BTE constants, state enum, `addr_next()` wrap function.
- Sub-module `wb_ram_bank_mem`: single-port synchronous byte-enabled RAM (DATA_WIDTH, DEPTH, INIT_FILE), read-old/write-separate, enable input; infers BRAM on Xilinx.

## Test plan
- Classic write 0xDEADBEEF, sel 1111, adr 0x0C; read 0x0C -> ack one cycle after stb, dat 0xDEADBEEF.
- Byte write 0x00AA0000 sel 0100 to 0x0C; read -> 0xDEAABEEF.
- Preload words 4..7 = 4,5,6,7; wrap4 read burst from adr 0x18 (word 6), 4 beats, last CTI=111 -> data 6,7,4,5, 5 cycles total.
- Linear write burst words 0..3 with stb low for 2 cycles after beat 1 -> ack low during gap, words read back correctly.
- adr = DEPTH*4 (just out of range), write -> err one cycle, no ack, dat_o 0, memory unchanged.
- rst_n asserted mid write burst after beat 2 -> ack/err 0 immediately, beats 3+ not written, next classic read works.

Source files
------------

// File: rtl/wb_ram_pkg.sv
// Shared constants, state encoding and burst address helper for wb_ram_bank.
package wb_ram_pkg;

    // Cycle type identifiers that change the slave's behaviour.
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    // Burst type extensions.
    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_BURST
    } state_e;

    // Next word index of a burst. Wrap modes increment only the low 2/3/4
    // bits and keep the upper bits fixed; linear increments the whole index.
    function automatic logic [31:0] addr_next(input logic [31:0] idx,
                                              input logic [1:0]  bte);
        logic [31:0] inc;
        logic [31:0] res;
        inc = idx + 32'd1;
        case (bte)
            BTE_WRAP4:  res = {idx[31:2], inc[1:0]};
            BTE_WRAP8:  res = {idx[31:3], inc[2:0]};
            BTE_WRAP16: res = {idx[31:4], inc[3:0]};
            default:    res = inc;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_ram_bank_mem.sv
// Single-port synchronous RAM with byte-lane write enables. Read-old
// behaviour: on a write cycle the output register captures the previous word.
module wb_ram_bank_mem #(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 8192,
  parameter string INIT_FILE  = ""
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   sel,
  input  logic [$clog2(DEPTH)-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata
);

  localparam int SW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-enabled write and registered read share one port.
  // NOTE: no reset on the array or its output register -- a reset term would
  // stop the tools mapping this onto block RAM; the top gates rdata instead.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < SW; b++) begin
        if (we && sel[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_ram_bank.sv
// Wishbone B3 slave RAM with registered ack, out-of-range error response and
// registered-feedback incrementing/wrapping bursts.
module wb_ram_bank
    import wb_ram_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    DEPTH      = 8192,
    parameter string INIT_FILE  = "",
    parameter bit    BURST_EN   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic [2:0]              wb_cti_i,
    input  logic [1:0]              wb_bte_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o
);

    localparam int SW  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(SW);
    localparam int AW  = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            err_q, err_d;

    logic            req;
    logic            out_of_range;
    logic            lin_ovf;
    logic [AW-1:0]   adr_idx;
    logic [AW-1:0]   addr_nx;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic            adr_unused;

    assign req          = wb_cyc_i & wb_stb_i;
    assign adr_idx      = wb_adr_i[LSB +: AW];
    assign out_of_range = |(wb_adr_i >> (LSB + AW));
    assign addr_nx      = AW'(addr_next(32'(addr_q), wb_bte_i));
    // Linear burst about to step past the last word: the following beat errs.
    assign lin_ovf      = (wb_bte_i == BTE_LINEAR) && (addr_q == '1);
    // Byte-offset bits select nothing inside a word.
    assign adr_unused   = ^wb_adr_i;

    // Termination is registered state, gated by the live request so a master
    // dropping cyc or stb never sees a stale ack.
    assign wb_ack_o = req & ~err_q & ((state_q == ST_SINGLE) || (state_q == ST_BURST));
    assign wb_err_o = req &  err_q &  (state_q != ST_IDLE);
    assign wb_dat_o = wb_ack_o ? mem_rdata : '0;

    // Next-state, address and error-flag logic.
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d = adr_idx;
                    if (out_of_range) begin
                        state_d = ST_SINGLE;
                        err_d   = 1'b1;
                    end else if (BURST_EN && (wb_cti_i == CTI_INCR)) begin
                        state_d = ST_BURST;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_SINGLE;
                        err_d   = 1'b0;
                    end
                end
            end
            ST_SINGLE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            ST_BURST: begin
                if (err_q) begin
                    if (req) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b0;
                    end
                end else if (wb_ack_o) begin
                    if (wb_cti_i == CTI_EOB) begin
                        state_d = ST_IDLE;
                    end else if (lin_ovf) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = addr_nx;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
        endcase
        if (!wb_cyc_i) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
        end
    end

    // Control registers; reset aborts any transfer immediately.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // Memory port steering: prefetch from the bus address when idle, write at
    // addr_q on ack beats, prefetch the next burst word on read beats.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = adr_idx;
        case (state_q)
            ST_IDLE: begin
                mem_en = req;
            end
            ST_SINGLE: begin
                mem_en   = wb_ack_o & wb_we_i;
                mem_we   = wb_ack_o & wb_we_i;
                mem_addr = addr_q;
            end
            ST_BURST: begin
                mem_en   = wb_ack_o;
                mem_we   = wb_ack_o & wb_we_i;
                mem_addr = wb_we_i ? addr_q : addr_nx;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    wb_ram_bank_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .INIT_FILE  (INIT_FILE)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .sel   (wb_sel_i),
        .addr  (mem_addr),
        .wdata (wb_dat_i),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_wb_ram_bank.sv
// Directed bench for wb_ram_bank: a table of classic transfers plus
// hand-written burst, wait-state, overflow and reset sequences.
module tb_wb_ram_bank;

    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_ram_bank #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .INIT_FILE  (""),
        .BURST_EN   (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_cti_i = 3'b000;
        wb_bte_i = 2'b00;
    endtask

    // One classic transfer: termination one cycle after the sampling edge,
    // and nothing in the cycle after that.
    task automatic classic(input vec_t v, input string tag);
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = v.we;
        wb_adr_i = v.adr;
        wb_dat_i = v.dat;
        wb_sel_i = v.sel;
        wb_cti_i = 3'b000;
        wb_bte_i = 2'b00;
        #1 check({tag, " pre"}, {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        @(negedge clk);
        check({tag, " ack"}, 32'(wb_ack_o), 32'(v.exp_ack));
        check({tag, " err"}, 32'(wb_err_o), 32'(v.exp_err));
        if (v.chk_dat) check({tag, " dat"}, wb_dat_o, v.exp_dat);
        @(negedge clk);
        check({tag, " one-cycle"}, {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        idle_bus();
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        vec_t v;
        v = '{1'b0, adr, 32'd0, 4'hF, 1'b1, 1'b0, 1'b1, exp};
        classic(v, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] wrap_exp [4];
        int nbeats;
        wrap_exp = '{32'd6, 32'd7, 32'd4, 32'd5};

        // Classic transfer table; word = adr/4, DEPTH*4 = 0x100 is out of range.
        vecs.push_back('{1'b1, 32'h0C, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0C, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h0C, 32'h00AA0000, 4'h4, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0C, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hDEAABEEF});
        vecs.push_back('{1'b0, 32'h0E, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hDEAABEEF});
        vecs.push_back('{1'b1, 32'h00, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h100, 32'h12345678, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h00, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5});
        vecs.push_back('{1'b0, 32'h80000000, 32'h0,  4'hF, 1'b0, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'hFC, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'hFC, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D});
        vecs.push_back('{1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h20, 32'hFFFFFFFF, 4'h9, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h20, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hFF2233FF});
        for (int w = 4; w < 8; w++)
            vecs.push_back('{1'b1, 32'(w*4), 32'(w), 4'hF, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h38, 32'h55555555, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h3C, 32'h55555555, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0});

        // Reset state, with a request presented to show it is ignored.
        rst_n    = 1'b0;
        wb_adr_i = 32'h0;
        wb_dat_i = 32'h0;
        wb_sel_i = 4'hF;
        idle_bus();
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reset ack", 32'(wb_ack_o), 32'd0);
        check("reset err", 32'(wb_err_o), 32'd0);
        check("reset dat", wb_dat_o, 32'd0);
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            classic(vecs[i], $sformatf("vec%0d", i));

        // Wrap4 read burst from word 6: data 6,7,4,5, five cycles in total.
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 32'h18; wb_cti_i = 3'b010; wb_bte_i = 2'b01; wb_sel_i = 4'hF;
        #1 check("wrap4 pre", 32'(wb_ack_o), 32'd0);
        nbeats = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) wb_cti_i = 3'b111;
            #1;
            check($sformatf("wrap4 beat%0d ack", i), 32'(wb_ack_o), 32'd1);
            check($sformatf("wrap4 beat%0d dat", i), wb_dat_o, wrap_exp[i]);
            if (wb_ack_o) nbeats++;
        end
        @(negedge clk);
        #1 check("wrap4 end", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        check("wrap4 beats", 32'(nbeats), 32'd4);
        idle_bus();

        // Linear write burst to words 0..3 with a two-cycle stb gap after beat 1.
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h0; wb_cti_i = 3'b010; wb_bte_i = 2'b00; wb_dat_i = 32'h100;
        @(negedge clk); #1 check("lin beat0", 32'(wb_ack_o), 32'd1);
        @(negedge clk); wb_dat_i = 32'h101; #1 check("lin beat1", 32'(wb_ack_o), 32'd1);
        @(negedge clk); wb_stb_i = 1'b0; #1 check("lin gap0", 32'(wb_ack_o), 32'd0);
        @(negedge clk); #1 check("lin gap1", 32'(wb_ack_o), 32'd0);
        @(negedge clk); wb_stb_i = 1'b1; wb_dat_i = 32'h102; #1 check("lin beat2", 32'(wb_ack_o), 32'd1);
        @(negedge clk); wb_dat_i = 32'h103; wb_cti_i = 3'b111; #1 check("lin beat3", 32'(wb_ack_o), 32'd1);
        @(negedge clk); #1 check("lin end", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        idle_bus();
        for (int w = 0; w < 4; w++)
            rd(32'(w*4), 32'h100 + 32'(w), $sformatf("lin rd%0d", w));

        // Linear burst from word 62: third beat runs off the end and errs.
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'hF8; wb_cti_i = 3'b010; wb_bte_i = 2'b00; wb_dat_i = 32'hE00;
        @(negedge clk); #1 check("ovf beat0", 32'(wb_ack_o), 32'd1);
        @(negedge clk); wb_dat_i = 32'hE01; #1 check("ovf beat1", 32'(wb_ack_o), 32'd1);
        @(negedge clk); wb_dat_i = 32'hE02; #1;
        check("ovf err", {30'd0, wb_ack_o, wb_err_o}, 32'd1);
        check("ovf dat", wb_dat_o, 32'd0);
        @(negedge clk); #1 check("ovf end", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        idle_bus();
        rd(32'hF8, 32'hE00, "ovf rd62");
        rd(32'hFC, 32'hE01, "ovf rd63");
        rd(32'h00, 32'h100, "ovf rd0");

        // Reset during a write burst to words 12..15 after two beats.
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h30; wb_cti_i = 3'b010; wb_bte_i = 2'b00; wb_dat_i = 32'h200;
        @(negedge clk); #1 check("rst beat1", 32'(wb_ack_o), 32'd1);
        @(negedge clk); wb_dat_i = 32'h201; #1 check("rst beat2", 32'(wb_ack_o), 32'd1);
        @(negedge clk); wb_dat_i = 32'h202; rst_n = 1'b0;
        #1 check("rst abort", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        @(negedge clk); wb_dat_i = 32'h203;
        #1 check("rst held", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;
        rd(32'h30, 32'h200,      "rst rd12");
        rd(32'h34, 32'h201,      "rst rd13");
        rd(32'h38, 32'h55555555, "rst rd14");
        rd(32'h3C, 32'h55555555, "rst rd15");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
